psk_framer: RTL and testbench

PSK_FRAMER -- requirements
Module: psk_framer

---
 rtl/psk_framer.sv | 138 +++++++++++++
 tb/tb_psk_framer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_framer.sv
// PSK frame builder: wraps upstream payload bytes with a 0x55 preamble, a 16-bit
// sync word and a trailing CRC-8, presented one byte at a time in a single output slot.
module psk_framer #(
    parameter int unsigned PARAMETER01 = 4,
    parameter int unsigned PARAMETER02 = 16,
    parameter logic [15:0] PARAMETER03 = 16'h2DD4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_empty,
    output logic       in_read,
    output logic [7:0] sample,
    output logic       empty,
    input  logic       read,
    output logic       busy
);
    localparam logic [7:0] PRE_LEN       = 8'(PARAMETER01);
    localparam logic [7:0] PAY_LEN       = 8'(PARAMETER02);
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC_HI,
        S_SYNC_LO,
        S_PAYLOAD,
        S_CRC
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [7:0] pay_cnt_q, pay_cnt_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] sample_q, sample_d;
    logic       slot_valid_q, slot_valid_d;
    logic       busy_q, busy_d;
    logic       avail;
    logic       load;
    logic [7:0] load_byte;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_cnt_q    <= '0;
            pay_cnt_q    <= '0;
            crc_q        <= '0;
            sample_q     <= '0;
            slot_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            pay_cnt_q    <= pay_cnt_d;
            crc_q        <= crc_d;
            sample_q     <= sample_d;
            slot_valid_q <= slot_valid_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        crc_d     = crc_q;
        busy_d    = busy_q;
        if (load) begin
            case (state_q)
                S_IDLE: begin
                    pre_cnt_d = 8'd1;
                    crc_d     = '0;
                    busy_d    = 1'b1;
                    // A one-byte preamble is already complete after this load
                    state_d   = (PRE_LEN == 8'd1) ? S_SYNC_HI : S_PREAMBLE;
                end
                S_PREAMBLE: begin
                    pre_cnt_d = pre_cnt_q + 8'd1;
                    if (pre_cnt_d == PRE_LEN) state_d = S_SYNC_HI;
                end
                S_SYNC_HI: state_d = S_SYNC_LO;
                S_SYNC_LO: begin
                    pay_cnt_d = '0;
                    state_d   = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    crc_d     = crc8_step(crc_q, in_data);
                    pay_cnt_d = pay_cnt_q + 8'd1;
                    if (pay_cnt_d == PAY_LEN) state_d = S_CRC;
                end
                S_CRC: begin
                    pre_cnt_d = '0;
                    pay_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        slot_valid_d = load | (slot_valid_q & ~read);
        sample_d     = load ? load_byte : sample_q;
    end

    always_comb begin
        avail     = 1'b1;
        load_byte = PREAMBLE_BYTE;
        case (state_q)
            S_IDLE:     avail = !in_empty;
            S_PREAMBLE: avail = 1'b1;
            S_SYNC_HI:  load_byte = PARAMETER03[15:8];
            S_SYNC_LO:  load_byte = PARAMETER03[7:0];
            S_PAYLOAD: begin
                avail     = !in_empty;
                load_byte = in_data;
            end
            S_CRC:      load_byte = crc_q;
            default:    avail = 1'b0;
        endcase
        load    = (!slot_valid_q || read) && enable && avail && !rst;
        in_read = load && (state_q == S_PAYLOAD);
    end

    assign sample = sample_q;
    assign empty  = !slot_valid_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_psk_framer.sv
// Bench for psk_framer: three instances (payload 16, 9 and 1 bytes) fed by show-ahead
// FIFO models, with a scoreboard of expected frame bytes per instance.
module tb_psk_framer;
    localparam int NI = 3;
    localparam int PRE = 4;
    localparam logic [15:0] SYNC = 16'h2DD4;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0]      enable_s;
    logic [NI-1:0]      read_s;
    logic [NI-1:0]      in_empty_s;
    logic [NI-1:0]      in_read_s;
    logic [NI-1:0]      empty_s;
    logic [NI-1:0]      busy_s;
    logic [NI-1:0][7:0] in_data_s;
    logic [NI-1:0][7:0] sample_s;
    logic [NI-1:0]      hold_s;
    logic [NI-1:0]      pop_pend;
    int                 pop_cnt [NI];

    logic [7:0] fifo_q [NI][$];
    logic [7:0] exp_q  [NI][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        psk_framer #(
            .PARAMETER01(PRE),
            .PARAMETER02((g == 0) ? 16 : ((g == 1) ? 9 : 1)),
            .PARAMETER03(SYNC)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable_s[g]),
            .in_data (in_data_s[g]),
            .in_empty(in_empty_s[g]),
            .in_read (in_read_s[g]),
            .sample  (sample_s[g]),
            .empty   (empty_s[g]),
            .read    (read_s[g]),
            .busy    (busy_s[g])
        );
    end

    // Upstream FIFO: apply the pop seen before the edge, then present the new head
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (pop_pend[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
            pop_pend[i] = 1'b0;
            in_empty_s[i] = hold_s[i] || (fifo_q[i].size() == 0);
            in_data_s[i] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 8'h00;
        end
    end

    // Output scoreboard: a presented byte must be the oldest expected byte
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            pop_pend[i] = in_read_s[i];
            if (in_read_s[i] === 1'b1) begin
                pop_cnt[i]++;
                checks++;
                if (in_empty_s[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL in_read_when_empty inst %0d: in_empty=%b, required 0", i, in_empty_s[i]);
                end
            end
            if (rst === 1'b0 && empty_s[i] === 1'b0) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte inst %0d: got %h, required no byte", i, sample_s[i]);
                end else begin
                    if (sample_s[i] !== exp_q[i][0]) begin
                        errors++;
                        $display("FAIL sample inst %0d: got %h, required %h", i, sample_s[i], exp_q[i][0]);
                    end
                    if (read_s[i] === 1'b1) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] crc8_ref(input logic [7:0] pl[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (pl[k]) begin
            c = c ^ pl[k];
            for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push_frame(input int inst, input logic [7:0] pl[$], input bit to_fifo);
        logic [15:0] sw;
        sw = SYNC;
        for (int k = 0; k < PRE; k++) exp_q[inst].push_back(8'h55);
        exp_q[inst].push_back(sw[15:8]);
        exp_q[inst].push_back(sw[7:0]);
        foreach (pl[k]) begin
            exp_q[inst].push_back(pl[k]);
            if (to_fifo) fifo_q[inst].push_back(pl[k]);
        end
        exp_q[inst].push_back(crc8_ref(pl));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        read_s = '1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (empty_s[i] !== 1'b1) begin errors++; $display("FAIL reset_empty inst %0d: got %b, required 1", i, empty_s[i]); end
            checks++;
            if (sample_s[i] !== 8'h00) begin errors++; $display("FAIL reset_sample inst %0d: got %h, required 00", i, sample_s[i]); end
            checks++;
            if (busy_s[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d: got %b, required 0", i, busy_s[i]); end
            checks++;
            if (in_read_s[i] !== 1'b0) begin errors++; $display("FAIL reset_in_read inst %0d: got %b, required 0", i, in_read_s[i]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_crc_vector();
        logic [7:0] want [15] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h31, 8'h32,
                                  8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'hF4};
        int base;
        int n;
        base = pop_cnt[1];
        foreach (want[k]) exp_q[1].push_back(want[k]);
        for (int k = 0; k < 9; k++) fifo_q[1].push_back(8'h31 + 8'(k));
        // the literal table above stops at 38 before F4; the ninth payload byte 39 sits before it
        exp_q[1].delete();
        for (int k = 0; k < 14; k++) exp_q[1].push_back(want[k]);
        exp_q[1].push_back(8'h39);
        exp_q[1].push_back(want[14]);
        n = 0;
        while (exp_q[1].size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (exp_q[1].size() != 0) begin errors++; $display("FAIL crc_vector_timeout: %0d bytes left, required 0", exp_q[1].size()); end
        tick();
        checks++;
        if (empty_s[1] !== 1'b1) begin errors++; $display("FAIL crc_vector_empty_after: got %b, required 1", empty_s[1]); end
        checks++;
        if (pop_cnt[1] - base != 9) begin errors++; $display("FAIL crc_vector_pops: got %0d, required 9", pop_cnt[1] - base); end
    endtask

    task automatic test_single_byte();
        logic [7:0] want [8] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h01, 8'h07};
        logic [7:0] pl[$];
        int base;
        int n;
        for (int f = 0; f < 2; f++) begin
            base = pop_cnt[2];
            if (f == 0) begin
                foreach (want[k]) exp_q[2].push_back(want[k]);
                fifo_q[2].push_back(8'h01);
            end else begin
                pl.delete();
                pl.push_back(8'($urandom_range(0, 255)));
                push_frame(2, pl, 1'b1);
            end
            n = 0;
            while (exp_q[2].size() != 0 && n < 60) begin tick(); n++; end
            checks++;
            if (exp_q[2].size() != 0) begin errors++; $display("FAIL single_timeout frame %0d: %0d bytes left, required 0", f, exp_q[2].size()); end
            tick();
            checks++;
            if (pop_cnt[2] - base != 1) begin errors++; $display("FAIL single_pops frame %0d: got %0d, required 1", f, pop_cnt[2] - base); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl[$];
        int base;
        int gaps;
        base = pop_cnt[0];
        for (int f = 0; f < 2; f++) begin
            pl.delete();
            for (int k = 0; k < 16; k++) pl.push_back(8'($urandom_range(0, 255)));
            push_frame(0, pl, 1'b1);
        end
        tick();
        checks++;
        if (empty_s[0] !== 1'b0 || sample_s[0] !== 8'h55) begin
            errors++;
            $display("FAIL first_byte_latency: empty=%b sample=%h, required empty=0 sample=55", empty_s[0], sample_s[0]);
        end
        gaps = 0;
        for (int k = 1; k < 46; k++) begin
            tick();
            if (empty_s[0] !== 1'b0) gaps++;
        end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL back_to_back_gaps: got %0d, required 0", gaps); end
        tick();
        checks++;
        if (empty_s[0] !== 1'b1) begin errors++; $display("FAIL back_to_back_end_empty: got %b, required 1", empty_s[0]); end
        checks++;
        if (exp_q[0].size() != 0) begin errors++; $display("FAIL back_to_back_left: got %0d bytes, required 0", exp_q[0].size()); end
        checks++;
        if (pop_cnt[0] - base != 32) begin errors++; $display("FAIL back_to_back_pops: got %0d, required 32", pop_cnt[0] - base); end
    endtask

    task automatic test_underrun();
        logic [7:0] pl[$];
        int base;
        int n;
        int viol;
        base = pop_cnt[0];
        for (int k = 0; k < 16; k++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(0, pl, 1'b1);
        n = 0;
        while (pop_cnt[0] - base < 3 && n < 100) begin tick(); n++; end
        hold_s[0] = 1'b1;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (in_read_s[0] !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL underrun_in_read: got %0d pulses, required 0", viol); end
        checks++;
        if (empty_s[0] !== 1'b1) begin errors++; $display("FAIL underrun_empty: got %b, required 1", empty_s[0]); end
        checks++;
        if (pop_cnt[0] - base != 3) begin errors++; $display("FAIL underrun_pops: got %0d, required 3", pop_cnt[0] - base); end
        hold_s[0] = 1'b0;
        n = 0;
        while (exp_q[0].size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (exp_q[0].size() != 0) begin errors++; $display("FAIL underrun_resume: %0d bytes left, required 0", exp_q[0].size()); end
    endtask

    task automatic test_slow_read();
        logic [7:0] pl[$];
        int n;
        int bad;
        for (int k = 0; k < 16; k++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(0, pl, 1'b1);
        n = 0;
        bad = 0;
        while (exp_q[0].size() != 0 && n < 400) begin
            read_s[0] = (n % 4 == 3);
            tick();
            n++;
            if (empty_s[0] === 1'b0 && exp_q[0].size() >= 2 && busy_s[0] !== 1'b1) bad++;
        end
        read_s[0] = 1'b1;
        checks++;
        if (exp_q[0].size() != 0) begin errors++; $display("FAIL slow_read_timeout: %0d bytes left, required 0", exp_q[0].size()); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL slow_read_busy: got %0d low cycles, required 0", bad); end
        tick();
    endtask

    task automatic test_enable_freeze();
        logic [7:0] pl[$];
        int base;
        int n;
        int viol;
        int busy_low;
        base = pop_cnt[0];
        for (int k = 0; k < 16; k++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(0, pl, 1'b1);
        n = 0;
        while (pop_cnt[0] - base < 5 && n < 100) begin tick(); n++; end
        enable_s[0] = 1'b0;
        viol = 0;
        busy_low = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (in_read_s[0] !== 1'b0) viol++;
            if (busy_s[0] !== 1'b1) busy_low++;
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL freeze_in_read: got %0d pulses, required 0", viol); end
        checks++;
        if (busy_low != 0) begin errors++; $display("FAIL freeze_busy: got %0d low cycles, required 0", busy_low); end
        checks++;
        if (empty_s[0] !== 1'b1) begin errors++; $display("FAIL freeze_slot_cleared: got empty=%b, required 1", empty_s[0]); end
        checks++;
        if (pop_cnt[0] - base != 5) begin errors++; $display("FAIL freeze_pops: got %0d, required 5", pop_cnt[0] - base); end
        enable_s[0] = 1'b1;
        n = 0;
        while (exp_q[0].size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (exp_q[0].size() != 0) begin errors++; $display("FAIL freeze_resume: %0d bytes left, required 0", exp_q[0].size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl[$];
        logic [7:0] rem[$];
        int n;
        for (int k = 0; k < 16; k++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(0, pl, 1'b1);
        n = 0;
        while (!(empty_s[0] === 1'b0 && sample_s[0] === 8'h2D) && n < 50) begin tick(); n++; end
        checks++;
        if (sample_s[0] !== 8'h2D) begin errors++; $display("FAIL mid_reset_sync_hi: got %h, required 2d", sample_s[0]); end
        rst = 1'b1;
        tick();
        checks++;
        if (empty_s[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: got %b, required 1", empty_s[0]); end
        checks++;
        if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", busy_s[0]); end
        rst = 1'b0;
        exp_q[0].delete();
        checks++;
        if (fifo_q[0].size() != 16) begin errors++; $display("FAIL mid_reset_popped: got %0d left, required 16", fifo_q[0].size()); end
        rem = fifo_q[0];
        push_frame(0, rem, 1'b0);
        n = 0;
        while (exp_q[0].size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (exp_q[0].size() != 0) begin errors++; $display("FAIL mid_reset_refill: %0d bytes left, required 0", exp_q[0].size()); end
        tick();
        checks++;
        if (empty_s[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_end_empty: got %b, required 1", empty_s[0]); end
    endtask

    initial begin
        rst = 1'b1;
        enable_s = '1;
        read_s = '0;
        hold_s = '0;
        in_empty_s = '1;
        in_data_s = '0;
        pop_pend = '0;
        for (int i = 0; i < NI; i++) pop_cnt[i] = 0;
        test_reset();
        test_crc_vector();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_slow_read();
        test_enable_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
